// File: rtl/xcvr_lb_pkg.sv
// Shared encodings for the XCVR loopback test sequencer and the lane checker.
package xcvr_lb_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_DP   = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_ALIGN    = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;
    localparam logic [2:0] ST_SNAP     = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    localparam logic [2:0] STATUS_PASS     = 3'd0;
    localparam logic [2:0] STATUS_RDY_TMO  = 3'd1;
    localparam logic [2:0] STATUS_LOCK_TMO = 3'd2;
    localparam logic [2:0] STATUS_DATA_ERR = 3'd3;
    localparam logic [2:0] STATUS_ABORTED  = 3'd4;

    // Busy spans the contiguous encodings RST_DP..SNAP.
    function automatic logic is_busy(input logic [2:0] st);
        return (st >= ST_RST_DP) && (st <= ST_SNAP);
    endfunction

endpackage

// File: rtl/lb_timer.sv
// Loadable down-counter; last_o flags the cycle on which the count reads 1.
module lb_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/xcvr_loopback_seq.sv
// Loopback lane test sequencer: reset datapath, wait ready/lock, run, snapshot errors, report.
module xcvr_loopback_seq
    import xcvr_lb_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned RDY_TIMEOUT  = 65535,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned SNAP_DLY     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_start_i,
    input  logic             cmd_abort_i,
    input  logic             cmd_inj_err_i,
    input  logic [CNT_W-1:0] run_len_i,
    input  logic             rx_ready_i,
    input  logic             lane_arst_n_i,
    input  logic             lock_i,
    input  logic [CNT_W-1:0] error_count_i,
    output logic             chk_rst_o,
    output logic             gen_en_o,
    output logic             chk_start_o,
    output logic             inj_err_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [2:0]       status_o,
    output logic [CNT_W-1:0] lol_count_o,
    output logic [CNT_W-1:0] result_count_o,
    output logic [1:0]       retry_count_o
);

    localparam logic [1:0] MAX_RETRY_L = 2'(MAX_RETRY);

    logic [2:0]       state_q, state_d;
    logic             chk_rst_q, done_q, pass_q, inj_err_q, injected_q;
    logic [2:0]       status_q;
    logic [CNT_W-1:0] lol_q, result_q, run_len_q;
    logic [1:0]       retry_q;

    logic             start_acc, abort_acc, inj_acc;
    logic             retry_inc, snap_take, enter_done, done_pass;
    logic [2:0]       done_status;
    logic             tmr_load, tmr_last;
    logic [CNT_W-1:0] tmr_val;

    assign start_acc = cmd_start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort_acc = cmd_abort_i && is_busy(state_q);
    assign inj_acc   = cmd_inj_err_i && (state_q == ST_RUN) && !injected_q;

    always_comb begin
        state_d     = state_q;
        retry_inc   = 1'b0;
        snap_take   = 1'b0;
        done_pass   = 1'b0;
        done_status = STATUS_PASS;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) state_d = ST_RST_DP;
            end
            ST_RST_DP: begin
                if (tmr_last) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (rx_ready_i && lane_arst_n_i) begin
                    state_d = ST_ALIGN;
                end else if (tmr_last) begin
                    state_d     = ST_DONE;
                    done_status = STATUS_RDY_TMO;
                end
            end
            ST_ALIGN: begin
                if (lock_i) begin
                    state_d = ST_RUN;
                end else if (tmr_last) begin
                    if (retry_q < MAX_RETRY_L) begin
                        state_d   = ST_RST_DP;
                        retry_inc = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        done_status = STATUS_LOCK_TMO;
                    end
                end
            end
            ST_RUN: begin
                // A lane reset restarts the whole bring-up; the run length starts over.
                if (!lane_arst_n_i && (retry_q < MAX_RETRY_L)) begin
                    state_d   = ST_RST_DP;
                    retry_inc = 1'b1;
                end else if (tmr_last) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                if (tmr_last) begin
                    state_d     = ST_DONE;
                    snap_take   = 1'b1;
                    done_pass   = (lol_q == '0) && (error_count_i == '0) && !injected_q;
                    done_status = done_pass ? STATUS_PASS : STATUS_DATA_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_acc) begin
            state_d     = ST_DONE;
            retry_inc   = 1'b0;
            snap_take   = 1'b0;
            done_pass   = 1'b0;
            done_status = STATUS_ABORTED;
        end
    end

    assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign tmr_load   = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        case (state_d)
            ST_RST_DP:   tmr_val = CNT_W'(RST_CYCLES);
            ST_WAIT_RDY: tmr_val = CNT_W'(RDY_TIMEOUT);
            ST_ALIGN:    tmr_val = CNT_W'(LOCK_TIMEOUT);
            ST_RUN:      tmr_val = run_len_q;
            ST_SNAP:     tmr_val = CNT_W'(SNAP_DLY);
            default:     tmr_val = '0;
        endcase
    end

    lb_timer #(.W(CNT_W)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .last_o     (tmr_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            chk_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            status_q   <= STATUS_PASS;
            inj_err_q  <= 1'b0;
            injected_q <= 1'b0;
            lol_q      <= '0;
            result_q   <= '0;
            run_len_q  <= '0;
            retry_q    <= '0;
        end else begin
            state_q   <= state_d;
            chk_rst_q <= (state_d == ST_RST_DP);
            done_q    <= enter_done;
            inj_err_q <= inj_acc;
            if (inj_acc) injected_q <= 1'b1;
            if (start_acc) begin
                run_len_q  <= (run_len_i == '0) ? CNT_W'(1) : run_len_i;
                lol_q      <= '0;
                result_q   <= '0;
                retry_q    <= '0;
                pass_q     <= 1'b0;
                status_q   <= STATUS_PASS;
                injected_q <= 1'b0;
            end
            if (retry_inc && (retry_q != 2'b11)) retry_q <= retry_q + 2'd1;
            if ((state_q == ST_RUN) && !lock_i && (lol_q != {CNT_W{1'b1}})) begin
                lol_q <= lol_q + CNT_W'(1);
            end
            if (snap_take) result_q <= error_count_i;
            if (enter_done) begin
                pass_q   <= done_pass;
                status_q <= done_status;
            end
        end
    end

    assign chk_rst_o      = chk_rst_q;
    assign gen_en_o       = (state_q == ST_ALIGN) || (state_q == ST_RUN) || (state_q == ST_SNAP);
    assign chk_start_o    = (state_q == ST_SNAP);
    assign inj_err_o      = inj_err_q;
    assign busy_o         = is_busy(state_q);
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign status_o       = status_q;
    assign lol_count_o    = lol_q;
    assign result_count_o = result_q;
    assign retry_count_o  = retry_q;

endmodule

// File: tb/tb_xcvr_loopback_seq.sv
// Scoreboard bench for xcvr_loopback_seq with a simple behavioural lane model.
module tb_xcvr_loopback_seq;
    import xcvr_lb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, cmd_start_i, cmd_abort_i, cmd_inj_err_i;
    logic [31:0] run_len_i, error_count_i;
    logic        rx_ready_i, lane_arst_n_i, lock_i;
    logic        chk_rst_o, gen_en_o, chk_start_o, inj_err_o, busy_o, done_o, pass_o;
    logic [2:0]  status_o;
    logic [31:0] lol_count_o, result_count_o;
    logic [1:0]  retry_count_o;

    always #5 clk = ~clk;

    xcvr_loopback_seq dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cmd_start_i    (cmd_start_i),
        .cmd_abort_i    (cmd_abort_i),
        .cmd_inj_err_i  (cmd_inj_err_i),
        .run_len_i      (run_len_i),
        .rx_ready_i     (rx_ready_i),
        .lane_arst_n_i  (lane_arst_n_i),
        .lock_i         (lock_i),
        .error_count_i  (error_count_i),
        .chk_rst_o      (chk_rst_o),
        .gen_en_o       (gen_en_o),
        .chk_start_o    (chk_start_o),
        .inj_err_o      (inj_err_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .status_o       (status_o),
        .lol_count_o    (lol_count_o),
        .result_count_o (result_count_o),
        .retry_count_o  (retry_count_o)
    );

    typedef struct {
        logic [2:0]  status;
        logic        pass;
        logic [1:0]  retry;
        logic [31:0] result;
        logic [31:0] lol;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [2:0] st, input logic p, input logic [1:0] r,
                                    input logic [31:0] res, input logic [31:0] lol, input string nm);
        exp_t e;
        e.status = st; e.pass = p; e.retry = r; e.result = res; e.lol = lol; e.name = nm;
        return e;
    endfunction

    // Lane model: RX_READY 50 cycles after datapath reset release, lock 20 cycles into gen_en.
    bit rdy_en = 1'b0, lock_en = 1'b0, lock_force_low = 1'b0;
    int rdy_cnt = 0, gen_cnt = 0;
    always @(negedge clk) begin
        if (chk_rst_o) rdy_cnt = 0; else if (rdy_cnt < 1000) rdy_cnt++;
        if (gen_en_o) begin
            if (gen_cnt < 1000) gen_cnt++;
        end else begin
            gen_cnt = 0;
        end
        rx_ready_i = rdy_en && (rdy_cnt >= 50);
        lock_i     = lock_en && (gen_cnt >= 20) && !lock_force_low;
    end

    int   busy_cyc = 0, wrdy_cyc = 0, rst_rises = 0, done_cnt = 0, inj_cnt = 0;
    logic chk_rst_prev = 1'b1;
    always @(posedge clk) begin
        #1;
        if (busy_o) busy_cyc++;
        if (busy_o && !chk_rst_o && !gen_en_o) wrdy_cyc++;
        if (chk_rst_o && !chk_rst_prev) rst_rises++;
        chk_rst_prev = chk_rst_o;
        if (done_o) done_cnt++;
        if (inj_err_o) inj_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        busy_cyc = 0; wrdy_cyc = 0; rst_rises = 0; done_cnt = 0; inj_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] len);
        run_len_i   = len;
        cmd_start_i = 1'b1;
        step();
        cmd_start_i = 1'b0;
    endtask

    task automatic wait_lock(input string tag, input int budget);
        for (int n = 0; n < budget && !lock_i; n++) step();
        check_eq({tag, "_lock_seen"}, lock_i, 1);
    endtask

    task automatic compare_result(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb_q.pop_front();
        $display("txn %s: status=%0d pass=%0d retry=%0d result=%0d lol=%0d", e.name,
                 status_o, pass_o, retry_count_o, result_count_o, lol_count_o);
        check_eq({e.name, "_status"}, status_o, e.status);
        check_eq({e.name, "_pass"}, pass_o, e.pass);
        check_eq({e.name, "_retry"}, retry_count_o, e.retry);
        check_eq({e.name, "_result"}, result_count_o, e.result);
        check_eq({e.name, "_lol"}, lol_count_o, e.lol);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int n = 0; n < budget && !done_o; n++) step();
        check_eq({tag, "_done_seen"}, done_o, 1);
        compare_result(tag);
    endtask

    initial begin
        rst_i = 1'b1; cmd_start_i = 1'b0; cmd_abort_i = 1'b0; cmd_inj_err_i = 1'b0;
        run_len_i = '0; error_count_i = '0; lane_arst_n_i = 1'b1;
        rx_ready_i = 1'b0; lock_i = 1'b0;
        step(3);
        check_eq("rst_chk_rst", chk_rst_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_gen_en", gen_en_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_pass", pass_o, 0);
        check_eq("rst_status", status_o, 0);
        rst_i = 1'b0;
        step(2);
        check_eq("idle_chk_rst", chk_rst_o, 0);

        // 1: ideal lane
        rdy_en = 1'b1; lock_en = 1'b1;
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_PASS, 1'b1, 2'd0, 0, 0, "ideal"));
        pulse_start(1000);
        wait_done("ideal", 5000);
        step(5);
        check_eq("ideal_done_once", done_cnt, 1);
        check_eq("ideal_busy_len", busy_cyc, 1000 + 16 + 73);
        check_eq("ideal_pass_held", pass_o, 1);

        // 2: RX_READY never rises
        rdy_en = 1'b0;
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_RDY_TMO, 1'b0, 2'd0, 0, 0, "rdy_tmo"));
        pulse_start(1000);
        wait_done("rdy_tmo", 70000);
        check_eq("rdy_tmo_wait_cycles", wrdy_cyc, 65535);
        rdy_en = 1'b1;

        // 3: lock never rises
        lock_en = 1'b0;
        step(3);
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_LOCK_TMO, 1'b0, 2'd3, 0, 0, "lock_tmo"));
        pulse_start(1000);
        wait_done("lock_tmo", 6000);
        check_eq("lock_tmo_rst_pulses", rst_rises, 4);
        lock_en = 1'b1;

        // 4: lane reset mid-run, one retry
        step(3);
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_PASS, 1'b1, 2'd1, 0, 0, "lane_rst"));
        pulse_start(1000);
        wait_lock("lane_rst", 500);
        step(200);
        lane_arst_n_i = 1'b0;
        step(4);
        lane_arst_n_i = 1'b1;
        wait_done("lane_rst", 5000);
        check_eq("lane_rst_rst_pulses", rst_rises, 2);

        // 5: injection outside RUN dropped, then one injection inside RUN
        step(3);
        clear_mon();
        cmd_inj_err_i = 1'b1; step(); cmd_inj_err_i = 1'b0;
        step(3);
        check_eq("inj_idle_dropped", inj_cnt, 0);
        error_count_i = 32'd5;
        sb_q.push_back(mk_exp(STATUS_DATA_ERR, 1'b0, 2'd0, 5, 0, "inject"));
        pulse_start(1000);
        wait_lock("inject", 500);
        step(10);
        cmd_inj_err_i = 1'b1; step(); cmd_inj_err_i = 1'b0;
        step(5);
        cmd_inj_err_i = 1'b1; step(); cmd_inj_err_i = 1'b0;
        wait_done("inject", 5000);
        check_eq("inject_pulses", inj_cnt, 1);
        error_count_i = '0;

        // 6: abort in RUN; start while busy ignored
        step(3);
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_ABORTED, 1'b0, 2'd0, 0, 0, "abort"));
        pulse_start(1000);
        wait_lock("abort", 500);
        step(300);
        pulse_start(50);
        check_eq("abort_start_ignored_busy", busy_o, 1);
        cmd_abort_i = 1'b1; step(); cmd_abort_i = 1'b0;
        check_eq("abort_done_next", done_o, 1);
        check_eq("abort_gen_off", gen_en_o, 0);
        compare_result("abort");

        // 7: lock lost for 5 RUN cycles
        step(3);
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_DATA_ERR, 1'b0, 2'd0, 0, 5, "lol"));
        pulse_start(1000);
        wait_lock("lol", 500);
        step(100);
        lock_force_low = 1'b1;
        step(5);
        lock_force_low = 1'b0;
        wait_done("lol", 5000);

        // 8: run length 0 behaves as 1
        step(3);
        clear_mon();
        sb_q.push_back(mk_exp(STATUS_PASS, 1'b1, 2'd0, 0, 0, "len0"));
        pulse_start(0);
        wait_done("len0", 2000);
        step(2);
        check_eq("len0_busy_len", busy_cyc, 16 + 50 + 20 + 1 + 3);

        // Abort in DONE ignored; start+abort together in DONE starts
        clear_mon();
        cmd_abort_i = 1'b1; step(); cmd_abort_i = 1'b0;
        step(2);
        check_eq("done_abort_status", status_o, STATUS_PASS);
        check_eq("done_abort_pass", pass_o, 1);
        check_eq("done_abort_no_done", done_cnt, 0);
        cmd_abort_i = 1'b1;
        pulse_start(1000);
        cmd_abort_i = 1'b0;
        check_eq("start_beats_abort_busy", busy_o, 1);
        check_eq("start_clears_pass", pass_o, 0);

        // Reset mid-test
        wait_lock("midrst", 500);
        step(50);
        rst_i = 1'b1; step(); 
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_chk_rst", chk_rst_o, 1);
        check_eq("midrst_gen_en", gen_en_o, 0);
        rst_i = 1'b0;
        step(5);
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
